// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the bit-serial adder.
//   start, sub, a, b, cin : operation request, sampled when the block is idle
//   busy, done            : progress / single-cycle result-valid pulse
//   sum, cout, ovf        : result, held until the next accepted start
// master = requester side, slave = serial_add_ctrl side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, LSB first, one full adder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if.slave (start/sub/a/b/cin in,
//           busy/done/sum/cout/ovf out)
// Timeline: start accepted at edge 0, bits produced at edges 1..WIDTH,
// one DONE cycle after edge WIDTH, back to IDLE at edge WIDTH+1.

// 1-bit full adder; the only arithmetic cell in the datapath.
module serial_add_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_c;
  assign o_c = (i_x & i_y) | (i_x & i_c) | (i_y & i_c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;
  logic             r_cmsb;   // carry into the MSB, kept for overflow
  logic [CW-1:0]    r_cnt;
  logic             w_load, w_step, w_last;
  logic             w_busy, w_done;
  logic             w_s, w_c;

  serial_add_fa u_fa (
    .i_x (r_a[0]),
    .i_y (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Counter holds the number of bits already produced.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: invert b on load and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_sum   <= '0;
      r_carry <= bus.sub | bus.cin;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_cmsb <= r_carry;
    end
  end

  // Result registers only move while loading or stepping, so they hold
  // from DONE until the next accepted start.
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_carry;
  assign bus.ovf  = r_cmsb ^ r_carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 instance for directed vectors,
// ignored-start and reset-abort cases, and a WIDTH=4 instance for the
// exhaustive sweep and the back-to-back start case. An arithmetic model
// (plain integer add, operation-time counter) is compared every cycle.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  st, sb, ci;
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic [1:0]  o_busy, o_done, o_cout, o_ovf;
  logic [31:0] o_sum [2];

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(4)) if4 ();

  assign if8.start = st[0];
  assign if8.sub   = sb[0];
  assign if8.a     = av[0][7:0];
  assign if8.b     = bv[0][7:0];
  assign if8.cin   = ci[0];
  assign o_busy[0] = if8.busy;
  assign o_done[0] = if8.done;
  assign o_cout[0] = if8.cout;
  assign o_ovf[0]  = if8.ovf;
  assign o_sum[0]  = {24'd0, if8.sum};

  assign if4.start = st[1];
  assign if4.sub   = sb[1];
  assign if4.a     = av[1][3:0];
  assign if4.b     = bv[1][3:0];
  assign if4.cin   = ci[1];
  assign o_busy[1] = if4.busy;
  assign o_done[1] = if4.done;
  assign o_cout[1] = if4.cout;
  assign o_ovf[1]  = if4.ovf;
  assign o_sum[1]  = {28'd0, if4.sum};

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int obs_done [2];

  // Model: m_t = cycles since the accepting edge (-1 when idle).
  int          m_t     [2];
  bit          m_valid [2];
  logic [31:0] m_sum   [2];
  logic        m_cout  [2];
  logic        m_ovf   [2];
  logic [31:0] p_sum   [2];
  logic        p_cout  [2];
  logic        p_ovf   [2];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic calc(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic c, output logic [31:0] r, output logic co, output logic ov);
    longint unsigned mask, x, y, t;
    mask = (64'd1 << w) - 64'd1;
    x    = longint'(a) & mask;
    y    = longint'(s ? ~b : b) & mask;
    t    = x + y + (s ? 64'd1 : {63'd0, c});
    r    = 32'(t & mask);
    co   = t[w];
    ov   = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = -1; m_valid[i] = 1'b1;
      m_sum[i] = '0; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    logic [31:0] r;
    logic co, ov;
    if (m_t[i] < 0) begin
      if (st[i]) begin
        calc(wid(i), sb[i], av[i], bv[i], ci[i], r, co, ov);
        p_sum[i] = r; p_cout[i] = co; p_ovf[i] = ov;
        m_t[i] = 0; m_valid[i] = 1'b0;
      end
    end else if (m_t[i] == wid(i)) begin
      m_t[i] = -1;
    end else begin
      m_t[i]++;
      if (m_t[i] == wid(i)) begin
        m_valid[i] = 1'b1;
        m_sum[i] = p_sum[i]; m_cout[i] = p_cout[i]; m_ovf[i] = p_ovf[i];
      end
    end
  endtask

  task automatic compare(input int i);
    string tag;
    tag = $sformatf("w%0d", wid(i));
    chk({tag, "_busy"}, 32'(o_busy[i]), 32'(m_t[i] >= 0));
    chk({tag, "_done"}, 32'(o_done[i]), 32'(m_t[i] == wid(i)));
    if (o_done[i]) obs_done[i]++;
    if (m_valid[i]) begin
      chk({tag, "_sum"},  o_sum[i],         m_sum[i]);
      chk({tag, "_cout"}, 32'(o_cout[i]),   32'(m_cout[i]));
      chk({tag, "_ovf"},  32'(o_ovf[i]),    32'(m_ovf[i]));
    end
  endtask

  // Inputs change only at the falling edge, right after the compare.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin model_step(0); model_step(1); end
    tick_no++;
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic run8(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [31:0] esum, input logic ecout, input logic eovf);
    int n;
    bit seen;
    sb[0] = s; av[0] = a; bv[0] = b; ci[0] = c; st[0] = 1'b1;
    tick();
    // Scramble the request after acceptance; the result must not move.
    st[0] = 1'b0; sb[0] = ~s; av[0] = ~a; bv[0] = ~b; ci[0] = ~c;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (o_done[0]) seen = 1'b1;
    end
    // Edge index (start edge = 0) at which a consumer first samples done.
    chk({name, "_lat"},  32'(n + 1), 32'd9);
    chk({name, "_sum"},  o_sum[0], esum);
    chk({name, "_cout"}, 32'(o_cout[0]), 32'(ecout));
    chk({name, "_ovf"},  32'(o_ovf[0]),  32'(eovf));
    tick();
  endtask

  initial begin
    int d0, bcnt, nd, last, first;
    st = '0; sb = '0; ci = '0;
    av = '{32'd0, 32'd0}; bv = '{32'd0, 32'd0};
    obs_done = '{0, 0};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compare(0); compare(1);
    chk("rst_busy", 32'(o_busy[0]), 32'd0);
    chk("rst_sum",  o_sum[0], 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    run8("add3c5a", 1'b0, 32'h3C, 32'h5A, 1'b0, 32'h96, 1'b0, 1'b1);
    run8("addff01", 1'b0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0);
    run8("add00c1", 1'b0, 32'h00, 32'h00, 1'b1, 32'h01, 1'b0, 1'b0);
    run8("sub1020", 1'b1, 32'h10, 32'h20, 1'b0, 32'hF0, 1'b0, 1'b0);
    run8("sub8001", 1'b1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1);
    run8("add7f01", 1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1);
    run8("sub0505", 1'b1, 32'h05, 32'h05, 1'b1, 32'h00, 1'b1, 1'b0);
    run8("addffc1", 1'b0, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 1'b0);

    // Starts during RUN (edge 3) and during DONE (edge 9) are ignored.
    d0 = obs_done[0];
    sb[0] = 1'b0; ci[0] = 1'b0; av[0] = 32'h01; bv[0] = 32'h01; st[0] = 1'b1;
    tick();
    st[0] = 1'b0; av[0] = 32'hFF; bv[0] = 32'hFF;
    bcnt = int'(o_busy[0]);
    repeat (2) begin tick(); bcnt += int'(o_busy[0]); end
    st[0] = 1'b1;
    tick(); bcnt += int'(o_busy[0]);
    st[0] = 1'b0;
    repeat (5) begin tick(); bcnt += int'(o_busy[0]); end
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (3) tick();
    chk("ign_busy_cycles", 32'(bcnt), 32'd9);
    chk("ign_done_cnt", 32'(obs_done[0] - d0), 32'd1);
    chk("ign_sum", o_sum[0], 32'h02);
    chk("ign_idle", 32'(o_busy[0]), 32'd0);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    d0 = obs_done[0];
    sb[0] = 1'b0; av[0] = 32'h3C; bv[0] = 32'h5A; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare(0); compare(1);
    chk("abort_busy", 32'(o_busy[0]), 32'd0);
    chk("abort_sum",  o_sum[0], 32'd0);
    chk("abort_cout", 32'(o_cout[0]), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("abort_no_done", 32'(obs_done[0] - d0), 32'd0);
    run8("after_rst", 1'b0, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0);

    // Start held high on the WIDTH=4 instance: one done every 6 cycles.
    sb[1] = 1'b0; ci[1] = 1'b0; av[1] = 32'h3; bv[1] = 32'h5; st[1] = 1'b1;
    nd = 0; last = 0; first = tick_no;
    for (int k = 0; k < 30; k++) begin
      if (k == 29) st[1] = 1'b0;
      tick();
      if (o_done[1]) begin
        if (nd > 0) chk("cont_period", 32'(tick_no - last), 32'd6);
        else        chk("cont_first",  32'(tick_no - first), 32'd5);
        last = tick_no; nd++;
      end
    end
    chk("cont_ndone", 32'(nd), 32'd5);
    chk("cont_sum", o_sum[1], 32'h8);
    chk("cont_ovf", 32'(o_ovf[1]), 32'd1);
    repeat (2) tick();

    // Exhaustive WIDTH=4 sweep; the per-cycle compare checks each result.
    d0 = obs_done[1];
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            sb[1] = s[0]; ci[1] = c[0]; av[1] = 32'(a); bv[1] = 32'(b); st[1] = 1'b1;
            tick();
            st[1] = 1'b0;
            repeat (5) tick();
          end
    chk("sweep_ndone", 32'(obs_done[1] - d0), 32'd1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
